// File: rtl/fp32_dot_seq.sv
// Issue-side sequencer for a pipelined FP32 MAC: one operand pair in flight at a time, result on a valid/ready port.
// Optional bias pass through the MAC is enabled by defining FP32_DOT_BIAS_EN.
module fp32_dot_seq #(
  parameter int MAC_LAT  = 5,
  parameter int LEN_W    = 16,
  parameter int WDOG_CYC = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             mac_valid,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  output logic             mac_use_acc,
  output logic             mac_clr_acc,
  input  logic             mac_valid_out,
  input  logic [31:0]      mac_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             busy
);

  localparam int          WD_W   = $clog2(WDOG_CYC + 1);
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  // A watchdog shorter than the MAC latency would fire on every healthy op.
  if (WDOG_CYC <= MAC_LAT) begin : g_cfg_chk
    $error("fp32_dot_seq: WDOG_CYC must exceed MAC_LAT");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ISSUE, S_WAIT,
`ifdef FP32_DOT_BIAS_EN
    S_BIAS, S_BWAIT,
`endif
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] rem;
  logic [WD_W-1:0]  wdog;
  logic [31:0]      result;
  logic             err;
  logic             wd_hit;

  assign wd_hit   = (wdog == WD_W'(WDOG_CYC));
  assign res_data = result;
  assign res_err  = err;
  assign busy     = (state != S_IDLE);

`ifdef FP32_DOT_BIAS_EN
  logic [31:0] bias_q;
  localparam state_t S_TAIL = S_BIAS;
`else
  logic unused_bias;
  assign unused_bias = ^cmd_bias;
  localparam state_t S_TAIL = S_DONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cmd_ready   = 1'b0;
    op_ready    = 1'b0;
    mac_use_acc = 1'b0;
    mac_clr_acc = 1'b0;
    res_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_CLR;
      end
      S_CLR: begin
        mac_clr_acc = 1'b1;
        state_nx    = (rem != '0) ? S_ISSUE : S_TAIL;
      end
      S_ISSUE: begin
        op_ready    = 1'b1;
        mac_use_acc = 1'b1;
        if (op_valid) state_nx = S_WAIT;
      end
      S_WAIT: begin
        mac_use_acc = 1'b1;
        if (mac_valid_out) state_nx = (rem == LEN_W'(1)) ? S_TAIL : S_ISSUE;
        else if (wd_hit)   state_nx = S_DONE;
      end
`ifdef FP32_DOT_BIAS_EN
      S_BIAS:  state_nx = S_BWAIT;
      S_BWAIT: if (mac_valid_out || wd_hit) state_nx = S_DONE;
`endif
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: mac_* are registered so the issue pulse lands one cycle after the op handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      wdog      <= '0;
      result    <= '0;
      err       <= 1'b0;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
`ifdef FP32_DOT_BIAS_EN
      bias_q    <= '0;
`endif
    end else begin
      mac_valid <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          rem    <= cmd_len;
          result <= '0;
          err    <= 1'b0;
`ifdef FP32_DOT_BIAS_EN
          bias_q <= cmd_bias;
`endif
        end
        S_ISSUE: if (op_valid) begin
          mac_a     <= op_a;
          mac_b     <= op_b;
          mac_c     <= '0;
          mac_valid <= 1'b1;
          wdog      <= '0;
        end
        S_WAIT: begin
          if (mac_valid_out) begin
            result <= mac_y;
            rem    <= rem - 1'b1;
          end else if (wd_hit) begin
            err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
`ifdef FP32_DOT_BIAS_EN
        // result*1.0 + bias, accumulator bypassed
        S_BIAS: begin
          mac_a     <= result;
          mac_b     <= FP_ONE;
          mac_c     <= bias_q;
          mac_valid <= 1'b1;
          wdog      <= '0;
        end
        S_BWAIT: begin
          if (mac_valid_out)  result <= mac_y;
          else if (wd_hit)    err    <= 1'b1;
          else                wdog   <= wdog + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_dot_seq.sv
// Directed bench for fp32_dot_seq with a scripted-latency MAC stub returning hand-computed partial sums.
module tb_fp32_dot_seq;
  localparam int MAC_LAT  = 5;
  localparam int LEN_W    = 16;
  localparam int WDOG_CYC = 20;
  localparam int PER      = MAC_LAT + 2;

  localparam logic [31:0] F_QTR = 32'h3E80_0000, F_HALF = 32'h3F00_0000, F_ONE = 32'h3F80_0000,
                          F_1P5 = 32'h3FC0_0000, F_TWO  = 32'h4000_0000, F_THR = 32'h4040_0000,
                          F_3P5 = 32'h4060_0000, F_FOUR = 32'h4080_0000, F_SIX = 32'h40C0_0000,
                          F_6P5 = 32'h40D0_0000, F_TEN  = 32'h4120_0000;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0] cmd_bias = '0;
  logic op_valid = 1'b1, op_ready;
  logic [31:0] op_a, op_b;
  logic mac_valid, mac_use_acc, mac_clr_acc, mac_valid_out;
  logic [31:0] mac_a, mac_b, mac_c, mac_y;
  logic res_valid, res_ready = 1'b0, res_err, busy;
  logic [31:0] res_data;

  fp32_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_use_acc(mac_use_acc), .mac_clr_acc(mac_clr_acc),
    .mac_valid_out(mac_valid_out), .mac_y(mac_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC stub: fixed latency, responses scripted in ytab
  logic [MAC_LAT-1:0] pipe = '0;
  logic [31:0] ytab [8];
  int  yidx = 0;
  logic mac_dead = 1'b0, arm = 1'b0;
  always @(posedge clk) begin
    pipe <= {pipe[MAC_LAT-2:0], mac_valid};
    if (!arm) yidx <= 0;
    else if (mac_valid_out) yidx <= yidx + 1;
  end
  assign mac_valid_out = pipe[MAC_LAT-1] && !mac_dead;
  assign mac_y = ytab[yidx % 8];

  // Monitor: records every issue pulse; op index follows the pulse count
  int npulse = 0, nclr = 0;
  int pt [8];
  logic [31:0] pa [8], pb [8], pc [8];
  logic pu [8];
  logic [31:0] cur_a [8], cur_b [8];
  assign op_a = cur_a[npulse % 8];
  assign op_b = cur_b[npulse % 8];
  always @(negedge clk) begin
    if (!arm) begin npulse = 0; nclr = 0; end
    else begin
      if (mac_valid) begin
        if (npulse < 8) begin
          pt[npulse] = cyc; pa[npulse] = mac_a; pb[npulse] = mac_b;
          pc[npulse] = mac_c; pu[npulse] = mac_use_acc;
        end
        npulse++;
      end
      if (mac_clr_acc) nclr++;
    end
  end

  int ntests = 0, nfail = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic rearm();
    @(negedge clk); arm = 1'b0;
    for (int k = 0; k < 8; k++) begin ytab[k] = '0; cur_a[k] = '0; cur_b[k] = '0; end
    @(negedge clk); @(negedge clk); arm = 1'b1;
  endtask

  task automatic start_cmd(input int len, input logic [31:0] bias, output int t0);
    bit ok = 0;
    @(negedge clk);
    cmd_len = LEN_W'(len); cmd_bias = bias; cmd_valid = 1'b1;
    t0 = -1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1; t0 = cyc; break; end
      @(negedge clk);
    end
    ntests++;
    if (!ok) begin nfail++; $display("FAIL cmd_accept: cmd_ready never seen"); end
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int t0, output int dt);
    dt = -1;
    for (int i = 0; i < 400; i++) begin
      if (res_valid) begin dt = cyc - t0; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " flags"}, 32'({cmd_ready, res_valid, res_err, mac_valid, mac_use_acc, mac_clr_acc, busy, op_ready}),
          32'b1000_0000);
    check({tag, " res_data"}, res_data, '0);
    check({tag, " mac_a"}, mac_a, '0);
    check({tag, " mac_b"}, mac_b, '0);
    check({tag, " mac_c"}, mac_c, '0);
  endtask

  typedef struct packed {
    int              len;
    logic [31:0]     bias;
    logic [3:0][31:0] a;   // element k at [k]
    logic [3:0][31:0] b;
    logic [3:0][31:0] y;   // MAC partial sums after op k
    logic [31:0]     yb;   // MAC response to the bias pass
  } vec_t;

  vec_t vt [4];

  initial begin
    int t0, dt, edt, elen, npexp;
    logic [31:0] eres;

    vt[0] = '{len: 4, bias: 32'h0,
              a: {F_FOUR, F_THR, F_TWO, F_ONE}, b: {F_ONE, F_ONE, F_ONE, F_ONE},
              y: {F_TEN, F_SIX, F_THR, F_ONE}, yb: F_TEN};
    vt[1] = '{len: 0, bias: F_HALF, a: '0, b: '0, y: '0, yb: F_HALF};
    vt[2] = '{len: 1, bias: F_HALF, a: {96'h0, F_TWO}, b: {96'h0, F_THR},
              y: {96'h0, F_SIX}, yb: F_6P5};
    vt[3] = '{len: 2, bias: 32'h0, a: {64'h0, F_TWO, F_1P5}, b: {64'h0, F_QTR, F_TWO},
              y: {64'h0, F_3P5, F_THR}, yb: F_3P5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    for (int i = 0; i < 4; i++) begin
      rearm();
      elen = vt[i].len;
      for (int k = 0; k < 4; k++) begin
        cur_a[k] = vt[i].a[k]; cur_b[k] = vt[i].b[k]; ytab[k] = vt[i].y[k];
      end
      ytab[elen] = vt[i].yb;
      edt   = (elen == 0) ? 2 : 4 + MAC_LAT + (elen - 1) * PER;
      eres  = (elen == 0) ? 32'h0 : vt[i].y[elen-1];
      npexp = elen;
`ifdef FP32_DOT_BIAS_EN
      edt   = edt + PER;
      eres  = vt[i].yb;
      npexp = elen + 1;
`endif
      start_cmd(elen, vt[i].bias, t0);
      wait_res(t0, dt);
      check($sformatf("v%0d res_time", i), dt, edt);
      check($sformatf("v%0d res_data", i), res_data, eres);
      check($sformatf("v%0d res_err", i), 32'(res_err), 0);
      check($sformatf("v%0d pulses", i), npulse, npexp);
      check($sformatf("v%0d clr_pulses", i), nclr, 1);
      for (int k = 0; k < elen; k++) begin
        check($sformatf("v%0d p%0d time", i, k), pt[k] - t0, 3 + k * PER);
        check($sformatf("v%0d p%0d a", i, k), pa[k], vt[i].a[k]);
        check($sformatf("v%0d p%0d b", i, k), pb[k], vt[i].b[k]);
        check($sformatf("v%0d p%0d c", i, k), pc[k], 32'h0);
        check($sformatf("v%0d p%0d use_acc", i, k), 32'(pu[k]), 1);
      end
`ifdef FP32_DOT_BIAS_EN
      check($sformatf("v%0d bias time", i), pt[elen] - t0, 3 + elen * PER);
      check($sformatf("v%0d bias a", i), pa[elen], (elen == 0) ? 32'h0 : vt[i].y[elen-1]);
      check($sformatf("v%0d bias b", i), pb[elen], F_ONE);
      check($sformatf("v%0d bias c", i), pc[elen], vt[i].bias);
      check($sformatf("v%0d bias use_acc", i), 32'(pu[elen]), 0);
`endif
      ack();
      check($sformatf("v%0d back_idle", i), 32'({cmd_ready, busy, res_valid}), 32'b100);
    end

    // Watchdog: MAC never answers
    rearm();
    mac_dead = 1'b1;
    cur_a[0] = F_ONE; cur_b[0] = F_ONE; cur_a[1] = F_ONE; cur_b[1] = F_ONE;
    start_cmd(2, 32'h0, t0);
    wait_res(t0, dt);
    check("wdog res_time", dt, 4 + WDOG_CYC);
    check("wdog res_err", 32'(res_err), 1);
    check("wdog res_data", res_data, 32'h0);
    check("wdog pulses", npulse, 1);
    ack();
    mac_dead = 1'b0;

    // Backpressure: result held while res_ready low
    rearm();
    cur_a[0] = F_TWO; cur_b[0] = F_THR; ytab[0] = F_SIX; ytab[1] = F_SIX;
    start_cmd(1, 32'h0, t0);
    wait_res(t0, dt);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d hold", k), 32'({res_valid, cmd_ready, busy, res_err}), 32'b1010);
      check($sformatf("bp%0d data", k), res_data, F_SIX);
    end
    ack();
    check("bp release", 32'({cmd_ready, busy, res_valid}), 32'b100);

    // Reset in WAIT, then a late MAC response while idle
    rearm();
    for (int k = 0; k < 2; k++) begin cur_a[k] = F_TWO; cur_b[k] = F_THR; end
    ytab[0] = 32'h7F00_0001; ytab[1] = F_SIX; ytab[2] = F_SIX;
    start_cmd(2, 32'h0, t0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (mac_valid) begin seen = 1; break; end
        @(negedge clk);
      end
      check("rst first_pulse_seen", 32'(seen), 1);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_idle("rst_mid");
    repeat (8) @(negedge clk);
    check("rst late_ignored", 32'({cmd_ready, busy, res_valid}), 32'b100);
    start_cmd(1, 32'h0, t0);
    wait_res(t0, dt);
`ifdef FP32_DOT_BIAS_EN
    check("rst new res_time", dt, 4 + MAC_LAT + PER);
`else
    check("rst new res_time", dt, 4 + MAC_LAT);
`endif
    check("rst new res_data", res_data, F_SIX);
    check("rst new res_err", 32'(res_err), 0);
    ack();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
